// File: rtl/stepper_motor_profile.sv
// stepper_motor_profile: trapezoidal motion-profile generator behind a Wishbone register file.
// It ramps velocity up, cruises, then ramps down so the move ends exactly at the target.
// Optional feature macro: STEPPER_MOTOR_PROFILE_IRQ_EN enables the IRQ registers and out_irq.
module stepper_motor_profile #(
  parameter int unsigned WB_ADR_WIDTH   = 8,
  parameter int unsigned WB_DAT_WIDTH   = 32,
  parameter int unsigned WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int unsigned STEP_WIDTH     = 16,
  parameter int unsigned DISTANCE_WIDTH = 32,
  parameter int unsigned PERIOD_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_we_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  output logic                    out_irq,
  output logic [STEP_WIDTH-1:0]   m_step,
  output logic                    m_enable,
  output logic                    m_dir
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAccel  = 3'd1,
    StCruise = 3'd2,
    StDecel  = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam logic [WB_ADR_WIDTH-1:0] AdrCoreId  = WB_ADR_WIDTH'(8'h00);
  localparam logic [WB_ADR_WIDTH-1:0] AdrCtl     = WB_ADR_WIDTH'(8'h04);
  localparam logic [WB_ADR_WIDTH-1:0] AdrStatus  = WB_ADR_WIDTH'(8'h05);
  localparam logic [WB_ADR_WIDTH-1:0] AdrIrqEn   = WB_ADR_WIDTH'(8'h08);
  localparam logic [WB_ADR_WIDTH-1:0] AdrIrqSt   = WB_ADR_WIDTH'(8'h09);
  localparam logic [WB_ADR_WIDTH-1:0] AdrTarget  = WB_ADR_WIDTH'(8'h10);
  localparam logic [WB_ADR_WIDTH-1:0] AdrMaxVel  = WB_ADR_WIDTH'(8'h12);
  localparam logic [WB_ADR_WIDTH-1:0] AdrAccel   = WB_ADR_WIDTH'(8'h13);
  localparam logic [WB_ADR_WIDTH-1:0] AdrPeriod  = WB_ADR_WIDTH'(8'h14);
  localparam logic [WB_ADR_WIDTH-1:0] AdrCurVel  = WB_ADR_WIDTH'(8'h18);
  localparam logic [WB_ADR_WIDTH-1:0] AdrCurDist = WB_ADR_WIDTH'(8'h19);
  localparam logic [31:0]             CoreId     = 32'hffff_3515;

  // Merge write data into an old register value under the byte enables.
  function automatic logic [WB_DAT_WIDTH-1:0] merge_be(input logic [WB_DAT_WIDTH-1:0] old_val,
                                                       input logic [WB_DAT_WIDTH-1:0] new_val,
                                                       input logic [WB_SEL_WIDTH-1:0] sel);
    logic [WB_DAT_WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(WB_SEL_WIDTH); i++) begin
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  state_e                    state_q, state_d;
  // Software-visible shadow registers.
  logic [DISTANCE_WIDTH-1:0] target_q, target_d;
  logic [STEP_WIDTH-1:0]     maxv_q, maxv_d, accel_q, accel_d;
  logic [PERIOD_WIDTH-1:0]   period_q, period_d;
  // Per-move snapshot and profile state.
  logic [DISTANCE_WIDTH-1:0] mag_q, mag_d;
  logic                      dir_q, dir_d;
  logic [STEP_WIDTH-1:0]     maxv_l_q, maxv_l_d, accel_l_q, accel_l_d;
  logic [PERIOD_WIDTH-1:0]   period_l_q, period_l_d;
  logic [DISTANCE_WIDTH-1:0] travelled_q, travelled_d, accel_dist_q, accel_dist_d;
  logic [PERIOD_WIDTH-1:0]   presc_q, presc_d;
  logic [STEP_WIDTH-1:0]     v_q, v_d;
  logic                      perr_q, perr_d;

  logic                      wr_en, start, abort, busy, tick;
  logic [DISTANCE_WIDTH-1:0] rem, step_amt, rem_next, target_abs;
  logic [STEP_WIDTH:0]       v_sum;
  logic [STEP_WIDTH-1:0]     v_dec, v_init;
  logic                      irq_en_rd, irq_st_rd;

  assign wr_en      = s_wb_stb_i & s_wb_we_i;
  assign start      = wr_en && (s_wb_adr_i == AdrCtl) && s_wb_sel_i[0] && s_wb_dat_i[0];
  assign abort      = wr_en && (s_wb_adr_i == AdrCtl) && s_wb_sel_i[0] && s_wb_dat_i[1];
  assign s_wb_ack_o = s_wb_stb_i;
  assign m_step     = v_q;
  assign m_enable   = busy;
  assign m_dir      = dir_q;

  // Shadow register writes with byte enables.
  always_comb begin
    target_d = target_q;
    maxv_d   = maxv_q;
    accel_d  = accel_q;
    period_d = period_q;
    if (wr_en) begin
      case (s_wb_adr_i)
        AdrTarget: target_d = DISTANCE_WIDTH'(merge_be(WB_DAT_WIDTH'(target_q), s_wb_dat_i,
                                                       s_wb_sel_i));
        AdrMaxVel: maxv_d   = STEP_WIDTH'(merge_be(WB_DAT_WIDTH'(maxv_q), s_wb_dat_i, s_wb_sel_i));
        AdrAccel:  accel_d  = STEP_WIDTH'(merge_be(WB_DAT_WIDTH'(accel_q), s_wb_dat_i, s_wb_sel_i));
        AdrPeriod: period_d = PERIOD_WIDTH'(merge_be(WB_DAT_WIDTH'(period_q), s_wb_dat_i,
                                                     s_wb_sel_i));
        default: ;
      endcase
    end
  end

  // Profile arithmetic shared by the FSM.
  always_comb begin
    busy       = (state_q == StAccel) || (state_q == StCruise) || (state_q == StDecel);
    tick       = busy && (presc_q == period_l_q);
    rem        = mag_q - travelled_q;
    step_amt   = (DISTANCE_WIDTH'(v_q) < rem) ? DISTANCE_WIDTH'(v_q) : rem;
    rem_next   = rem - step_amt;
    v_sum      = {1'b0, v_q} + {1'b0, accel_l_q};
    // max(v - accel, accel); the accel floor guarantees the move terminates.
    v_dec      = ((v_q > accel_l_q) && ((v_q - accel_l_q) > accel_l_q)) ? (v_q - accel_l_q)
                                                                         : accel_l_q;
    v_init     = (accel_q < maxv_q) ? accel_q : maxv_q;
    target_abs = target_q[DISTANCE_WIDTH-1] ? -target_q : target_q;
  end

  // Motion FSM next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    mag_d        = mag_q;
    dir_d        = dir_q;
    maxv_l_d     = maxv_l_q;
    accel_l_d    = accel_l_q;
    period_l_d   = period_l_q;
    travelled_d  = travelled_q;
    accel_dist_d = accel_dist_q;
    presc_d      = presc_q;
    v_d          = v_q;
    perr_d       = perr_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          mag_d        = target_abs;
          dir_d        = target_q[DISTANCE_WIDTH-1];
          maxv_l_d     = maxv_q;
          accel_l_d    = accel_q;
          period_l_d   = period_q;
          travelled_d  = '0;
          accel_dist_d = '0;
          presc_d      = '0;
          if ((accel_q == '0) || (maxv_q == '0)) begin
            perr_d  = 1'b1;
            state_d = StDone;
          end else if (target_abs == '0) begin
            perr_d  = 1'b0;
            state_d = StDone;
          end else begin
            perr_d  = 1'b0;
            v_d     = v_init;
            state_d = StAccel;
          end
        end
      end
      StAccel, StCruise, StDecel: begin
        if (abort) begin
          state_d = StIdle;
          v_d     = '0;
        end else if (tick) begin
          presc_d     = '0;
          travelled_d = travelled_q + step_amt;
          if (state_q == StAccel) accel_dist_d = accel_dist_q + step_amt;
          if (rem_next == '0) begin
            state_d = StDone;
            v_d     = '0;
          end else if ((state_q != StDecel) &&
                       (rem_next <= accel_dist_q + ((state_q == StAccel) ? step_amt : '0))) begin
            state_d = StDecel;
            v_d     = v_dec;
          end else if (state_q == StAccel) begin
            if (v_sum >= {1'b0, maxv_l_q}) begin
              v_d     = maxv_l_q;
              state_d = StCruise;
            end else begin
              v_d = v_sum[STEP_WIDTH-1:0];
            end
          end else if (state_q == StDecel) begin
            v_d = v_dec;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Register file and motion state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      target_q     <= '0;
      maxv_q       <= '0;
      accel_q      <= '0;
      period_q     <= '0;
      mag_q        <= '0;
      dir_q        <= 1'b0;
      maxv_l_q     <= '0;
      accel_l_q    <= '0;
      period_l_q   <= '0;
      travelled_q  <= '0;
      accel_dist_q <= '0;
      presc_q      <= '0;
      v_q          <= '0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      maxv_q       <= maxv_d;
      accel_q      <= accel_d;
      period_q     <= period_d;
      mag_q        <= mag_d;
      dir_q        <= dir_d;
      maxv_l_q     <= maxv_l_d;
      accel_l_q    <= accel_l_d;
      period_l_q   <= period_l_d;
      travelled_q  <= travelled_d;
      accel_dist_q <= accel_dist_d;
      presc_q      <= presc_d;
      v_q          <= v_d;
      perr_q       <= perr_d;
    end
  end

`ifdef STEPPER_MOTOR_PROFILE_IRQ_EN
  localparam logic [WB_ADR_WIDTH-1:0] AdrIrqClr = WB_ADR_WIDTH'(8'h0a);
  localparam logic [WB_ADR_WIDTH-1:0] AdrIrqSet = WB_ADR_WIDTH'(8'h0b);

  logic irq_en_q, irq_en_d, irq_st_q, irq_st_d, done_entry;

  // IRQ enable/status; a completion set takes priority over a same-cycle clear.
  always_comb begin
    irq_en_d   = irq_en_q;
    irq_st_d   = irq_st_q;
    done_entry = (state_d == StDone) && (state_q != StDone);
    if (wr_en && s_wb_sel_i[0]) begin
      if (s_wb_adr_i == AdrIrqEn) irq_en_d = s_wb_dat_i[0];
      if ((s_wb_adr_i == AdrIrqClr) && s_wb_dat_i[0]) irq_st_d = 1'b0;
      if ((s_wb_adr_i == AdrIrqSet) && s_wb_dat_i[0]) irq_st_d = 1'b1;
    end
    if (done_entry) irq_st_d = 1'b1;
  end

  // IRQ registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_st_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_st_q <= irq_st_d;
    end
  end

  assign out_irq   = irq_st_q & irq_en_q;
  assign irq_en_rd = irq_en_q;
  assign irq_st_rd = irq_st_q;
`else
  assign out_irq   = 1'b0;
  assign irq_en_rd = 1'b0;
  assign irq_st_rd = 1'b0;
`endif

  // Combinational read mux.
  always_comb begin
    s_wb_dat_o = '0;
    case (s_wb_adr_i)
      AdrCoreId:  s_wb_dat_o = WB_DAT_WIDTH'(CoreId);
      AdrStatus:  s_wb_dat_o = WB_DAT_WIDTH'({perr_q, state_q, busy});
      AdrIrqEn:   s_wb_dat_o = WB_DAT_WIDTH'(irq_en_rd);
      AdrIrqSt:   s_wb_dat_o = WB_DAT_WIDTH'(irq_st_rd);
      AdrTarget:  s_wb_dat_o = WB_DAT_WIDTH'(target_q);
      AdrMaxVel:  s_wb_dat_o = WB_DAT_WIDTH'(maxv_q);
      AdrAccel:   s_wb_dat_o = WB_DAT_WIDTH'(accel_q);
      AdrPeriod:  s_wb_dat_o = WB_DAT_WIDTH'(period_q);
      AdrCurVel:  s_wb_dat_o = WB_DAT_WIDTH'(v_q);
      AdrCurDist: s_wb_dat_o = WB_DAT_WIDTH'(travelled_q);
      default:    s_wb_dat_o = '0;
    endcase
  end

endmodule

// File: doc/stepper_motor_profile.md
# stepper_motor_profile

Trapezoidal motion-profile controller for the stepper PWM stage. Software writes a signed target distance, acceleration, maximum velocity and tick period over Wishbone, then issues start. The block ramps velocity up, cruises, and ramps down so motion ends exactly at the target. It drives the PWM stage's step-rate, enable and direction inputs, and raises an interrupt on completion.

## Interface
- WB_ADR_WIDTH, 8, Wishbone address width (word address).
- WB_DAT_WIDTH, 32, Wishbone data width.
- WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width.
- STEP_WIDTH, 16, velocity / step-rate width (unsigned).
- DISTANCE_WIDTH, 32, target and travelled-distance width; target is signed.
- PERIOD_WIDTH, 16, tick prescaler width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset; all state clears on assertion.
- s_wb_adr_i  in  WB_ADR_WIDTH  register address.
- s_wb_dat_o  out  WB_DAT_WIDTH  read data (combinational).
- s_wb_dat_i  in  WB_DAT_WIDTH  write data.
- s_wb_sel_i  in  WB_SEL_WIDTH  byte enables.
- s_wb_we_i  in  1  write strobe qualifier.
- s_wb_stb_i  in  1  strobe.
- s_wb_ack_o  out  1  ack, equal to s_wb_stb_i (zero wait).
- out_irq  out  1  irq_status & irq_enable.
- m_step  out  STEP_WIDTH  current velocity, fed to the PWM stage's step input.
- m_enable  out  1  high while in ACCEL/CRUISE/DECEL.
- m_dir  out  1  1 when the latched target is negative.

## Operation
- Registers:
  - 0x00 CORE_ID: reads 0xffff3515.
  - 0x04 CTL_CONTROL: write-only pulses. Bit0 start, bit1 abort.
  - 0x05 CTL_STATUS: read-only. Bit0 busy, bits[3:1] state, bit4 param_error.
  - 0x08 IRQ_ENABLE, 0x09 IRQ_STATUS, 0x0a IRQ_CLR, 0x0b IRQ_SET.
  - 0x10 TARGET, 0x12 MAX_VELOCITY, 0x13 ACCEL, 0x14 TICK_PERIOD.
  - 0x18 CUR_VELOCITY and 0x19 CUR_DISTANCE: read-only.
- Byte writes are honoured through s_wb_sel_i.
- Parameter registers are shadows. They are snapshotted at start, so writes while busy do not affect the current move.
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.
- Start in IDLE:
  - Latch mag = |TARGET| as unsigned DISTANCE_WIDTH; 0x8000_0000 gives 2^31. Latch dir = TARGET sign.
  - Clear travelled, accel_dist and the prescaler.
  - If ACCEL==0 or MAX_VELOCITY==0: set param_error and go to DONE.
  - Else if mag==0: go to DONE.
  - Else: set v = min(ACCEL, MAX_VELOCITY) and go to ACCEL. param_error is cleared.
- Start while busy is ignored.
- Tick: the prescaler counts 0..TICK_PERIOD and pulses tick on the cycle count==TICK_PERIOD, then reloads 0. It runs only in ACCEL/CRUISE/DECEL.
- On each tick:
  - Let rem = mag − travelled and s = min(v, rem).
  - travelled += s. In ACCEL only, accel_dist += s. rem' = rem − s.
  - If rem'==0: go to DONE and set v = 0.
  - Else if state is ACCEL or CRUISE and rem' ≤ accel_dist: go to DECEL and set v = max(v − ACCEL, ACCEL).
  - Else if ACCEL: compute v+ACCEL at STEP_WIDTH+1 bits. If the sum ≥ MAX_VELOCITY, set v = MAX_VELOCITY and go to CRUISE; otherwise v = the sum.
  - Else if DECEL: v = max(v − ACCEL, ACCEL). The floor guarantees termination.
- DONE lasts exactly one cycle, then IDLE. It sets irq_status on entry, including for the param_error and zero-distance cases.
- Abort in any busy state: go to IDLE next cycle with v = 0, no IRQ; travelled is retained. Abort in IDLE or DONE has no effect.
- If start and abort are written in the same cycle, abort wins.
- If a DONE-entry irq_status set coincides with an IRQ_CLR write in the same cycle, the set wins.

## Timing
- Reset values:
  - m_step=0, m_enable=0, m_dir=0, out_irq=0, state IDLE.
  - TICK_PERIOD=0; all other registers 0.
- Register writes take effect the cycle after stb&we.
- Start written in cycle N: state=ACCEL and m_enable=1 in N+1; m_step=v_initial in N+1.
- First tick occurs in cycle N+1+TICK_PERIOD.
- m_step, m_enable, state and irq_status are registered and change the cycle after the tick or control write.
- m_enable falls and m_step becomes 0 in the DONE cycle; IDLE follows one cycle later.
- out_irq rises in the DONE cycle.

## Configuration
- STEPPER_MOTOR_PROFILE_IRQ_EN defined: IRQ registers and out_irq behave as described above.
- Not defined:
  - out_irq is tied to 0.
  - IRQ_ENABLE and IRQ_STATUS read 0; writes to 0x08–0x0b are ignored.
  - DONE still occurs, and completion is visible only through CTL_STATUS.

## Test plan
- TARGET=10, ACCEL=1, MAX_VELOCITY=4, TICK_PERIOD=0, start -> m_step sequence 1,2,3,2,1,1 on successive cycles, then 0. CUR_DISTANCE=10; DONE one cycle; IRQ status=1.
- TARGET=−20, ACCEL=2, MAX_VELOCITY=4, TICK_PERIOD=3 -> m_dir=1; ticks every 4 cycles; CRUISE entered at v=4; final CUR_DISTANCE=20.
- Abort written two ticks into a move -> IDLE next cycle, m_step=0, m_enable=0, no IRQ; CUR_DISTANCE unchanged.
- ACCEL=0, start -> DONE next cycle, param_error=1, m_enable never high, IRQ set.
- Start rewritten during motion with a new TARGET -> profile unaffected; new TARGET is used on the next start only.
- Async reset asserted mid-CRUISE -> all outputs 0 immediately, without waiting for a clock edge; IDLE after release.
